// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, keeps one word read in flight and holds
// the returned instruction in a single output register for decode.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   // state | meaning
   // IDLE  | no read outstanding; may issue when the output slot is free or being consumed
   // WAIT  | read outstanding; its response fills the output slot
   // DRAIN | read outstanding but flushed by a redirect; its response is thrown away
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] req_pc;
   logic        accept;
   logic        consume;

   // Request is combinational so a new fetch can overlap the cycle decode takes the slot.
   assign mem_valid = reset_n && (state == IDLE) && !redirect_valid && (!inst_valid || inst_ready);
   assign mem_addr  = pc;
   assign accept    = mem_valid && mem_ready;
   assign consume   = inst_valid && inst_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         req_pc     <= 32'h0;
         inst_valid <= 1'b0;
         inst       <= 32'h0;
         inst_pc    <= 32'h0;
      end else if (redirect_valid) begin
         pc         <= {redirect_pc[31:2], 2'b00};
         inst_valid <= 1'b0;
         if (state == WAIT)
            state <= mem_rvalid ? IDLE : DRAIN;
      end else begin
         if (consume)
            inst_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  req_pc <= pc;
                  pc     <= pc + 32'd4;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  inst       <= mem_rdata;
                  inst_pc    <= req_pc;
                  inst_valid <= 1'b1;
                  state      <= IDLE;
               end
            end
            DRAIN: begin
               if (mem_rvalid)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
